// File: rtl/mux_nx1_rr_pkg.sv
// Shared constants and helpers for the N:1 registered stream multiplexer.
// Used by mux_nx1_rr, its interface and its round-robin arbiter.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   XFER_CNT_W = 16;

    // Index width for n items; never below one bit so a 1-bit select is always legal.
    function automatic int clog2_safe(input int n);
        int r;
        r = $clog2(n);
        if (r < 1) begin
            r = 1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_nx1_rr_if.sv
// Stream bundle between N producers, the multiplexer and one consumer.
// slave = multiplexer side, master = producer/consumer side.
interface mux_nx1_rr_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);

    logic [NCH*WIDTH-1:0]                 in_data;
    logic [NCH-1:0]                       in_valid;
    logic [NCH-1:0]                       in_ready;
    logic [WIDTH-1:0]                     out_data;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [mux_pkg::clog2_safe(NCH)-1:0]  out_ch;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_ch
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_ch
    );

endinterface

// File: rtl/mux_nx1_rr_arbiter.sv
// Combinational round-robin grant: first requester at or above ptr, wrapping
// from NCH-1 back to 0.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NCH   = 4,
    localparam int SEL_W = clog2_safe(NCH)
) (
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    output logic [NCH-1:0]   gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any_gnt
);

    logic [SEL_W:0]   sum_s;
    logic [SEL_W-1:0] idx_s;
    logic             found_s;

    // Scan the NCH positions in priority order starting from ptr.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_gnt    = 1'b0;
        found_s    = 1'b0;
        sum_s      = '0;
        idx_s      = '0;
        for (int k = 0; k < NCH; k++) begin
            sum_s = {1'b0, ptr} + (SEL_W+1)'(k);
            if (sum_s >= (SEL_W+1)'(NCH)) begin
                sum_s = sum_s - (SEL_W+1)'(NCH);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[SEL_W-1:0];
            if (!found_s && req[idx_s]) begin
                found_s           = 1'b1;
                gnt_onehot[idx_s] = 1'b1;
                gnt_idx           = idx_s;
                any_gnt           = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// Registered N:1 valid/ready stream multiplexer with fixed-select and round-robin modes.
// Optional MUX_STATS_EN adds a saturating 16-bit output-transfer counter port xfer_cnt.
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    localparam int SEL_W = clog2_safe(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    mux_nx1_rr_if.slave      bus
`ifdef MUX_STATS_EN
    ,
    output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);

    logic [NCH-1:0]   arb_onehot_s;
    logic [SEL_W-1:0] arb_idx_s;
    logic             arb_any_s;

    logic             can_load_s;
    logic [NCH-1:0]   in_ready_s;
    logic [SEL_W-1:0] gnt_idx_s;
    logic             load_s;
    logic             drain_s;
    logic [WIDTH-1:0] sel_data_s;

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req        (bus.in_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (arb_onehot_s),
        .gnt_idx    (arb_idx_s),
        .any_gnt    (arb_any_s)
    );

    assign can_load_s = !out_valid_q || bus.out_ready;
    assign drain_s    = out_valid_q && bus.out_ready;

    // Ready steering: only the chosen channel may see can_load; nothing is ready in reset.
    always_comb begin
        in_ready_s = '0;
        gnt_idx_s  = '0;
        if (rst) begin
            in_ready_s = '0;
        end else if (mode == MODE_RR) begin
            gnt_idx_s = arb_idx_s;
            if (arb_any_s) begin
                in_ready_s = arb_onehot_s & {NCH{can_load_s}};
            end else begin
                in_ready_s = '0;
            end
        end else begin
            gnt_idx_s = sel;
            if (int'(sel) < NCH) begin
                in_ready_s[sel] = can_load_s;
            end else begin
                in_ready_s = '0;
            end
        end
    end

    assign load_s = |(in_ready_s & bus.in_valid);

    // Data path select for the granted channel.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_idx_s == SEL_W'(i)) begin
                sel_data_s = bus.in_data[i*WIDTH +: WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Next state of the output slot and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_s) begin
            out_data_d  = sel_data_s;
            out_ch_d    = gnt_idx_s;
            out_valid_d = 1'b1;
        end else if (drain_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        // The pointer only advances on round-robin grants so fixed-mode traffic leaves it untouched.
        if (load_s && (mode == MODE_RR)) begin
            if (int'(gnt_idx_s) == NCH - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx_s + SEL_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Output slot and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

`ifdef MUX_STATS_EN
    logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    // Saturating count of output transfers.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (drain_s && (xfer_cnt_q != {XFER_CNT_W{1'b1}})) begin
            xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(1);
        end else begin
            xfer_cnt_d = xfer_cnt_q;
        end
    end

    // Transfer counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule
